ins_fetch: RTL and testbench

INS_FETCH -- requirements
Module: ins_fetch

---
 rtl/ins_fetch.sv | 130 +++++++++++++
 tb/tb_ins_fetch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch.sv
// Instruction byte fetch: ROM request FSM feeding a small in-order byte buffer.
// Define INS_FETCH_PREFETCH_EN for a 2-entry buffer (prefetch); default is 1 entry.
module ins_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        pc_load,
   input  logic [15:0] pc_new,
   output logic [15:0] rom_addr,
   output logic        rom_rd,
   input  logic [7:0]  rom_data,
   input  logic        rom_ack,
   output logic        ins_valid,
   output logic [7:0]  ins_data,
   output logic [15:0] ins_pc,
   input  logic        ins_ready
);

`ifdef INS_FETCH_PREFETCH_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif
   localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

   state_e      state_q;
   logic [15:0] fpc_q;
   logic [1:0]  count_q;
   logic [7:0]  buf_data_q [DEPTH];
   logic [15:0] buf_pc_q   [DEPTH];

   logic       push;
   logic       pop;
   logic       slot_free;
   logic [1:0] wr_idx;

   assign ins_valid = (count_q != 2'd0);
   assign ins_data  = buf_data_q[0];
   assign ins_pc    = buf_pc_q[0];

   // A redirect suppresses both push and pop; the buffer is flushed instead.
   always_comb begin
      push      = (state_q == StWait) && rom_ack && !pc_load;
      pop       = ins_valid && ins_ready && !pc_load;
      slot_free = (count_q < DEPTH_CNT);
      wr_idx    = count_q - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_data_q[i] <= 8'h00;
            buf_pc_q[i]   <= 16'h0000;
         end
      end else if (pc_load) begin
         count_q <= 2'd0;
      end else begin
         if (push && !pop) begin
            count_q <= count_q + 2'd1;
         end else if (pop && !push) begin
            count_q <= count_q - 2'd1;
         end
         // Head is always slot 0; a pop shifts everything down one slot.
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (2'(i) == wr_idx)) begin
               buf_data_q[i] <= rom_data;
               buf_pc_q[i]   <= fpc_q;
            end else if (pop) begin
               buf_data_q[i] <= buf_data_q[(i + 1) % DEPTH];
               buf_pc_q[i]   <= buf_pc_q[(i + 1) % DEPTH];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         fpc_q    <= RESET_PC;
         rom_rd   <= 1'b0;
         rom_addr <= 16'h0000;
      end else begin
         rom_rd <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pc_load) begin
                  fpc_q <= pc_new;
               end else if (fetch_en && slot_free) begin
                  state_q  <= StReq;
                  rom_rd   <= 1'b1;
                  rom_addr <= fpc_q;
               end
            end
            StReq: begin
               if (pc_load) begin
                  fpc_q   <= pc_new;
                  state_q <= StDrop;
               end else begin
                  state_q <= StWait;
               end
            end
            StWait: begin
               // An ack in the redirect cycle already retires the request.
               if (pc_load) begin
                  fpc_q   <= pc_new;
                  state_q <= rom_ack ? StIdle : StDrop;
               end else if (rom_ack) begin
                  fpc_q   <= fpc_q + 16'd1;
                  state_q <= StIdle;
               end
            end
            StDrop: begin
               if (pc_load) begin
                  fpc_q <= pc_new;
               end
               if (rom_ack) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch with a latency-programmable ROM model.
// Build with or without INS_FETCH_PREFETCH_EN; expectations follow the macro.
module tb_ins_fetch;

`ifdef INS_FETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        fetch_en;
   logic        pc_load;
   logic [15:0] pc_new;
   logic [15:0] rom_addr;
   logic        rom_rd;
   logic [7:0]  rom_data;
   logic        rom_ack;
   logic        ins_valid;
   logic [7:0]  ins_data;
   logic [15:0] ins_pc;
   logic        ins_ready;

   always #5 clk = ~clk;

   ins_fetch #(
      .RESET_PC(16'h0100)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .fetch_en (fetch_en),
      .pc_load  (pc_load),
      .pc_new   (pc_new),
      .rom_addr (rom_addr),
      .rom_rd   (rom_rd),
      .rom_data (rom_data),
      .rom_ack  (rom_ack),
      .ins_valid(ins_valid),
      .ins_data (ins_data),
      .ins_pc   (ins_pc),
      .ins_ready(ins_ready)
   );

   // ROM: byte at address A is A[7:0] + 8'h30; acks ack_lat cycles after rom_rd.
   int          ack_lat = 1;
   logic        model_ack = 1'b0;
   logic [7:0]  model_data = 8'h00;
   logic        stale_ack = 1'b0;
   logic [7:0]  stale_data = 8'h00;
   logic        busy = 1'b0;
   int          cnt = 0;
   logic [15:0] pend = 16'h0000;

   assign rom_ack  = model_ack | stale_ack;
   assign rom_data = stale_ack ? stale_data : model_data;

   always @(posedge clk) begin
      model_ack <= 1'b0;
      if (!rst_n) begin
         busy <= 1'b0;
      end else if (rom_rd) begin
         if (ack_lat <= 1) begin
            model_ack  <= 1'b1;
            model_data <= rom_addr[7:0] + 8'h30;
         end else begin
            busy <= 1'b1;
            cnt  <= ack_lat - 1;
            pend <= rom_addr;
         end
      end else if (busy) begin
         if (cnt == 1) begin
            model_ack  <= 1'b1;
            model_data <= pend[7:0] + 8'h30;
            busy       <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   logic [15:0] addr_log[$];
   logic [15:0] rx_pc[$];
   logic [7:0]  rx_data[$];

   always @(posedge clk) begin
      if (rst_n) begin
         if (rom_rd) addr_log.push_back(rom_addr);
         if (ins_valid && ins_ready && !pc_load) begin
            rx_pc.push_back(ins_pc);
            rx_data.push_back(ins_data);
         end
      end
   end

   function automatic logic [15:0] log_at(int i);
      return (i < addr_log.size()) ? addr_log[i] : 16'hDEAD;
   endfunction

   function automatic logic [15:0] rx_pc_at(int i);
      return (i < rx_pc.size()) ? rx_pc[i] : 16'hDEAD;
   endfunction

   function automatic logic [7:0] rx_data_at(int i);
      return (i < rx_data.size()) ? rx_data[i] : 8'hDD;
   endfunction

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   int base_a;
   int base_r;

   initial begin
      fetch_en  = 1'b0;
      pc_load   = 1'b0;
      pc_new    = 16'h0000;
      ins_ready = 1'b0;
      rst_n     = 1'b0;
      cycles(2);
      check("rst_rom_rd", 32'(rom_rd), 32'h0);
      check("rst_rom_addr", 32'(rom_addr), 32'h0000);
      check("rst_valid", 32'(ins_valid), 32'h0);
      check("rst_data", 32'(ins_data), 32'h00);
      check("rst_pc", 32'(ins_pc), 32'h0000);

      // Sequential fetch from RESET_PC, 1-cycle ack, decoder always ready.
      rst_n = 1'b1;
      cycles(1);
      fetch_en  = 1'b1;
      ins_ready = 1'b1;
      @(negedge clk);
      check("lat_c1_rd", 32'(rom_rd), 32'h1);
      check("lat_c1_addr", 32'(rom_addr), 32'h0100);
      check("lat_c1_valid", 32'(ins_valid), 32'h0);
      @(negedge clk);
      check("lat_c2_valid", 32'(ins_valid), 32'h0);
      check("lat_c2_rd", 32'(rom_rd), 32'h0);
      @(negedge clk);
      check("lat_c3_valid", 32'(ins_valid), 32'h1);
      check("lat_c3_pc", 32'(ins_pc), 32'h0100);
      check("lat_c3_data", 32'(ins_data), 32'h30);
      cycles(16);
      fetch_en = 1'b0;
      cycles(10);
      check("seq_addr0", 32'(log_at(0)), 32'h0100);
      check("seq_addr1", 32'(log_at(1)), 32'h0101);
      check("seq_addr2", 32'(log_at(2)), 32'h0102);
      check("seq_pc0", 32'(rx_pc_at(0)), 32'h0100);
      check("seq_pc1", 32'(rx_pc_at(1)), 32'h0101);
      check("seq_pc2", 32'(rx_pc_at(2)), 32'h0102);
      check("seq_data0", 32'(rx_data_at(0)), 32'h30);
      check("seq_data1", 32'(rx_data_at(1)), 32'h31);
      check("seq_data2", 32'(rx_data_at(2)), 32'h32);

      // Decoder stalled: head stays put, buffer fills to DEPTH, then drains in order.
      rst_n = 1'b0;
      cycles(2);
      rst_n  = 1'b1;
      base_a = addr_log.size();
      base_r = rx_pc.size();
      ins_ready = 1'b0;
      fetch_en  = 1'b1;
      cycles(3);
      for (int i = 0; i < 10; i++) begin
         check("hold_pc", 32'(ins_pc), 32'h0100);
         check("hold_data", 32'(ins_data), 32'h30);
         @(negedge clk);
      end
      fetch_en = 1'b0;
      cycles(2);
      check("hold_nreq", 32'(addr_log.size() - base_a), 32'(DEPTH));
      check("hold_valid", 32'(ins_valid), 32'h1);
      ins_ready = 1'b1;
      cycles(4);
      check("drain_n", 32'(rx_pc.size() - base_r), 32'(DEPTH));
      check("drain_pc0", 32'(rx_pc_at(base_r)), 32'h0100);
      check("drain_data0", 32'(rx_data_at(base_r)), 32'h30);
`ifdef INS_FETCH_PREFETCH_EN
      check("drain_pc1", 32'(rx_pc_at(base_r + 1)), 32'h0101);
      check("drain_data1", 32'(rx_data_at(base_r + 1)), 32'h31);
`endif
      check("drain_empty", 32'(ins_valid), 32'h0);

      // Fetch pointer wraps from FFFF to 0000.
      base_a  = addr_log.size();
      base_r  = rx_pc.size();
      pc_load = 1'b1;
      pc_new  = 16'hFFFF;
      @(negedge clk);
      pc_load  = 1'b0;
      fetch_en = 1'b1;
      cycles(20);
      fetch_en = 1'b0;
      cycles(8);
      check("wrap_addr0", 32'(log_at(base_a)), 32'hFFFF);
      check("wrap_addr1", 32'(log_at(base_a + 1)), 32'h0000);
      check("wrap_pc0", 32'(rx_pc_at(base_r)), 32'hFFFF);
      check("wrap_data0", 32'(rx_data_at(base_r)), 32'h2F);
      check("wrap_pc1", 32'(rx_pc_at(base_r + 1)), 32'h0000);
      check("wrap_data1", 32'(rx_data_at(base_r + 1)), 32'h30);

      // Redirect while waiting on a slow ROM: late byte is dropped.
      ack_lat  = 3;
      fetch_en = 1'b1;
      for (int i = 0; i < 20 && !rom_rd; i++) @(negedge clk);
      check("drop_rd_seen", 32'(rom_rd), 32'h1);
      @(negedge clk);
      base_a  = addr_log.size();
      base_r  = rx_pc.size();
      pc_load = 1'b1;
      pc_new  = 16'h0040;
      @(negedge clk);
      pc_load = 1'b0;
      check("drop_flush", 32'(ins_valid), 32'h0);
      cycles(30);
      fetch_en = 1'b0;
      cycles(10);
      check("drop_addr0", 32'(log_at(base_a)), 32'h0040);
      check("drop_pc0", 32'(rx_pc_at(base_r)), 32'h0040);
      check("drop_data0", 32'(rx_data_at(base_r)), 32'h70);
      check("drop_pc1", 32'(rx_pc_at(base_r + 1)), 32'h0041);

      // Redirect coinciding with a pop (and, with prefetch, a same-cycle ack).
      ack_lat   = 1;
      ins_ready = 1'b0;
      fetch_en  = 1'b1;
`ifdef INS_FETCH_PREFETCH_EN
      for (int i = 0; i < 30 && !(ins_valid && rom_ack); i++) @(negedge clk);
      check("coin_ack", 32'(rom_ack), 32'h1);
`else
      for (int i = 0; i < 30 && !ins_valid; i++) @(negedge clk);
`endif
      check("coin_valid", 32'(ins_valid), 32'h1);
      base_a    = addr_log.size();
      base_r    = rx_pc.size();
      ins_ready = 1'b1;
      pc_load   = 1'b1;
      pc_new    = 16'h0500;
      @(negedge clk);
      pc_load = 1'b0;
      check("coin_flush", 32'(ins_valid), 32'h0);
      cycles(20);
      fetch_en = 1'b0;
      cycles(8);
      check("coin_addr0", 32'(log_at(base_a)), 32'h0500);
      check("coin_pc0", 32'(rx_pc_at(base_r)), 32'h0500);
      check("coin_data0", 32'(rx_data_at(base_r)), 32'h30);

      // Reset mid-WAIT, then a stale ack must not produce a byte.
      ack_lat  = 20;
      fetch_en = 1'b1;
      for (int i = 0; i < 20 && !rom_rd; i++) @(negedge clk);
      check("rw_rd_seen", 32'(rom_rd), 32'h1);
      @(negedge clk);
      rst_n    = 1'b0;
      fetch_en = 1'b0;
      #1;
      check("rw_async_rd", 32'(rom_rd), 32'h0);
      check("rw_async_addr", 32'(rom_addr), 32'h0000);
      check("rw_async_valid", 32'(ins_valid), 32'h0);
      check("rw_async_pc", 32'(ins_pc), 32'h0000);
      @(negedge clk);
      rst_n  = 1'b1;
      base_a = addr_log.size();
      @(negedge clk);
      stale_data = 8'hEE;
      stale_ack  = 1'b1;
      @(negedge clk);
      stale_ack = 1'b0;
      check("rw_stale_valid0", 32'(ins_valid), 32'h0);
      cycles(2);
      check("rw_stale_valid1", 32'(ins_valid), 32'h0);
      ack_lat  = 1;
      fetch_en = 1'b1;
      for (int i = 0; i < 20 && !ins_valid; i++) @(negedge clk);
      check("rw_fresh_valid", 32'(ins_valid), 32'h1);
      check("rw_fresh_pc", 32'(ins_pc), 32'h0100);
      check("rw_fresh_data", 32'(ins_data), 32'h30);
      check("rw_fresh_addr", 32'(log_at(base_a)), 32'h0100);
      fetch_en = 1'b0;
      cycles(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
